// File: rtl/serial_tx_arbiter_if.sv
// Requester handshakes and framed serial line of the two-requester serial transmitter.
interface serial_tx_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             serial_out;
    logic             frame_active;
    logic             grant_id;

    modport master (
        output req0_valid,
        output req0_data,
        input  req0_ready,
        output req1_valid,
        output req1_data,
        input  req1_ready,
        input  serial_out,
        input  frame_active,
        input  grant_id
    );

    modport slave (
        input  req0_valid,
        input  req0_data,
        output req0_ready,
        input  req1_valid,
        input  req1_data,
        output req1_ready,
        output serial_out,
        output frame_active,
        output grant_id
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter for two word requesters driving one serial line framed as
// start bit (1), WIDTH data bits MSB first, stop bit (0); idle line level is 0.
module serial_tx_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input logic                clk,
    input logic                reset,
    serial_tx_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StStart, StShift, StStop} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;

    logic any_valid;
    logic sel;
    logic ready0;
    logic ready1;
    logic handshake;

    // On a tie the requester that did not own the previous frame wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            sel = ~last_q;
        end else begin
            sel = bus.req1_valid;
        end
        ready0    = (state_q == StIdle) && !reset && any_valid && !sel;
        ready1    = (state_q == StIdle) && !reset && any_valid && sel;
        handshake = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        serial_d = serial_q;
        active_d = active_q;
        grant_d  = grant_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                serial_d = 1'b0;
                active_d = 1'b0;
                if (handshake) begin
                    shreg_d  = sel ? bus.req1_data : bus.req0_data;
                    grant_d  = sel;
                    last_d   = sel;
                    serial_d = 1'b1;
                    active_d = 1'b1;
                    state_d  = StStart;
                end
            end
            StStart: begin
                serial_d = shreg_q[WIDTH-1];
                shreg_d  = shreg_q << 1;
                cnt_d    = CntW'(WIDTH - 1);
                state_d  = StShift;
            end
            StShift: begin
                // cnt_q is the index of the bit currently on the line.
                if (cnt_q == '0) begin
                    serial_d = 1'b0;
                    state_d  = StStop;
                end else begin
                    serial_d = shreg_q[WIDTH-1];
                    shreg_d  = shreg_q << 1;
                    cnt_d    = cnt_q - CntW'(1);
                end
            end
            StStop: begin
                serial_d = 1'b0;
                active_d = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
            active_q <= 1'b0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            active_q <= active_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.serial_out   = serial_q;
    assign bus.frame_active = active_q;
    assign bus.grant_id     = grant_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: fixed vector table, directed corner sequences and
// random traffic checked against a frame-queue reference model.
module tb_serial_tx_arbiter;
    localparam int unsigned W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_tx_arbiter_if #(.WIDTH(W)) bus ();

    serial_tx_arbiter #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each accepted word becomes a queue of line bits.
    bit   m_line[$];
    bit   m_serial = 1'b0;
    bit   m_active = 1'b0;
    bit   m_grant  = 1'b0;
    bit   m_last   = 1'b1;
    bit   e_r0, e_r1;
    logic s_r0, s_r1;

    typedef struct {
        bit           rst;
        bit           v0;
        logic [W-1:0] d0;
        bit           v1;
        logic [W-1:0] d1;
        bit           r0;
        bit           r1;
        bit           ser;
        bit           act;
        bit           gnt;
    } vec_t;
    vec_t vecs[$];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v0, input logic [W-1:0] d0,
                         input bit v1, input logic [W-1:0] d1);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
    endtask

    task automatic model_accept(input bit g, input logic [W-1:0] d);
        m_grant = g;
        m_last  = g;
        m_line.push_back(1'b1);
        for (int i = W - 1; i >= 0; i--) m_line.push_back(d[i]);
        m_line.push_back(1'b0);
    endtask

    // One clock: ready sampled mid-cycle, registered outputs sampled 1 after the edge.
    task automatic tick();
        @(negedge clk);
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!reset && !m_active) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (m_last) e_r0 = 1'b1;
                else e_r1 = 1'b1;
            end else if (bus.req0_valid) begin
                e_r0 = 1'b1;
            end else if (bus.req1_valid) begin
                e_r1 = 1'b1;
            end
        end
        s_r0 = bus.req0_ready;
        s_r1 = bus.req1_ready;
        check_bit("model_ready0", s_r0, e_r0);
        check_bit("model_ready1", s_r1, e_r1);
        @(posedge clk);
        if (reset) begin
            m_line.delete();
            m_serial = 1'b0;
            m_active = 1'b0;
            m_grant  = 1'b0;
            m_last   = 1'b1;
        end else begin
            if (e_r0 && bus.req0_valid) model_accept(1'b0, bus.req0_data);
            else if (e_r1 && bus.req1_valid) model_accept(1'b1, bus.req1_data);
            if (m_line.size() > 0) begin
                m_serial = m_line.pop_front();
                m_active = 1'b1;
            end else begin
                m_serial = 1'b0;
                m_active = 1'b0;
            end
        end
        #1;
        check_bit("model_serial", bus.serial_out, m_serial);
        check_bit("model_active", bus.frame_active, m_active);
        check_bit("model_grant", bus.grant_id, m_grant);
    endtask

    task automatic add_row(input bit rst, input bit v0, input logic [W-1:0] d0,
                           input bit v1, input logic [W-1:0] d1, input bit r0, input bit r1,
                           input bit ser, input bit act, input bit gnt);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.ser = ser; v.act = act; v.gnt = gnt;
        vecs.push_back(v);
    endtask

    // Seven rows: handshake, four data bits, stop bit, return to idle.
    task automatic add_frame(input bit g, input logic [W-1:0] d, input bit hold,
                             input bit v0, input logic [W-1:0] d0,
                             input bit v1, input logic [W-1:0] d1);
        add_row(1'b0, v0, d0, v1, d1, !g, g, 1'b1, 1'b1, g);
        for (int i = 1; i <= 6; i++) begin
            bit ser;
            bit act;
            ser = (i <= W) ? d[W-i] : 1'b0;
            act = (i <= W + 1);
            add_row(1'b0, hold && v0, d0, hold && v1, d1, 1'b0, 1'b0, ser, act, g);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
    endtask

    initial begin
        int            found;
        logic [W-1:0] word;

        drive(1'b1, 4'b0000, 1'b1, 4'b0000);

        for (int i = 0; i < 3; i++)
            add_row(1'b1, 1'b1, 4'b0101, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_frame(1'b0, 4'b1010, 1'b0, 1'b1, 4'b1010, 1'b0, 4'b0000);
        add_row(1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) begin
            bit g;
            g = f[0];
            add_frame(g, g ? 4'b0001 : 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001);
        end

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
            tick();
            check_bit($sformatf("vec%0d_ready0", i), s_r0, vecs[i].r0);
            check_bit($sformatf("vec%0d_ready1", i), s_r1, vecs[i].r1);
            check_bit($sformatf("vec%0d_serial", i), bus.serial_out, vecs[i].ser);
            check_bit($sformatf("vec%0d_active", i), bus.frame_active, vecs[i].act);
            check_bit($sformatf("vec%0d_grant", i), bus.grant_id, vecs[i].gnt);
        end

        // Valid raised mid-frame waits for IDLE: accepted at E+7.
        do_reset(2);
        drive(1'b0, 4'b0000, 1'b1, 4'b0110);
        tick();
        check_bit("t4_req1_accept", s_r1, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 4'b0110);
        tick();
        tick();
        drive(1'b1, 4'b0101, 1'b0, 4'b0110);
        found = -1;
        for (int k = 3; k <= 20 && found < 0; k++) begin
            tick();
            if (s_r0 === 1'b1) found = k;
        end
        check_int("t4_accept_edge", found, 7);
        check_bit("t4_grant", bus.grant_id, 1'b0);
        drive(1'b0, 4'b0000, 1'b0, 4'b0000);
        for (int k = 0; k < 8; k++) tick();

        // Reset during the third data bit aborts; held valid restarts a full frame.
        do_reset(1);
        drive(1'b1, 4'b1011, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        check_bit("t5_ready_in_reset", s_r0, 1'b0);
        check_bit("t5_abort_serial", bus.serial_out, 1'b0);
        check_bit("t5_abort_active", bus.frame_active, 1'b0);
        check_bit("t5_abort_grant", bus.grant_id, 1'b0);
        reset = 1'b0;
        tick();
        check_bit("t5_reaccept", s_r0, 1'b1);
        check_bit("t5_start_bit", bus.serial_out, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 4'b0000);
        word = '0;
        for (int k = 0; k < W; k++) begin
            tick();
            word = {word[W-2:0], bus.serial_out};
        end
        check_int("t5_data", int'(word), 11);
        tick();
        check_bit("t5_stop_bit", bus.serial_out, 1'b0);
        tick();

        // Requester data changes after the handshake must not reach the line.
        do_reset(1);
        drive(1'b1, 4'b1100, 1'b0, 4'b0000);
        tick();
        drive(1'b0, 4'b0011, 1'b0, 4'b0000);
        word = '0;
        for (int k = 0; k < W; k++) begin
            tick();
            word = {word[W-2:0], bus.serial_out};
        end
        check_int("t6_frozen_data", int'(word), 12);
        tick();
        tick();
        check_bit("t6_idle_grant_held", bus.grant_id, 1'b0);

        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 2) != 0,
                  W'($urandom));
            tick();
        end

        reset = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        for (int k = 0; k < 10; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
